// File: rtl/eco32f_registerfile_mp.sv
// Multi-read-port pipeline register file with EX/MEM forwarding and hazard detection.
// Forwarding is built only when ECO32F_RF_FORWARD_EN is defined; otherwise all RAW matches stall ID.
module eco32f_registerfile_mp #(
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_stall,
  input  logic                           ex_stall,
  input  logic [NUM_RD-1:0]              id_rd_valid,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   id_rd_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   ex_rd_addr,
  input  logic [ADDR_WIDTH-1:0]          ex_rf_r_addr,
  input  logic                           ex_rf_r_we,
  input  logic                           ex_rf_r_load,
  output logic [ADDR_WIDTH-1:0]          mem_rf_r_addr,
  output logic                           mem_rf_r_we,
  input  logic [DATA_WIDTH-1:0]          mem_alu_result,
  output logic [NUM_RD*DATA_WIDTH-1:0]   ex_rd_data,
  output logic                           id_hazard,
  input  logic [ADDR_WIDTH-1:0]          wb_rf_r_addr,
  input  logic                           wb_rf_r_we,
  input  logic [DATA_WIDTH-1:0]          wb_rf_r
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DW-1:0]              regs [DEPTH];
  logic [NUM_RD-1:0][DW-1:0]  rd_q;
  logic [NUM_RD-1:0][AW-1:0]  id_addr_c;
  logic [NUM_RD-1:0][AW-1:0]  ex_addr_c;
  logic [NUM_RD-1:0]          id_zero_c;
  logic [NUM_RD-1:0]          ex_zero_c;
  logic                       wb_en_c;
  logic                       mem_load;
  logic                       unused_c;

  // Unpack port addresses and flag hard-wired-zero reads
  always_comb begin
    id_addr_c = '0;
    ex_addr_c = '0;
    id_zero_c = '0;
    ex_zero_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      id_addr_c[i] = id_rd_addr[i*AW +: AW];
      ex_addr_c[i] = ex_rd_addr[i*AW +: AW];
      id_zero_c[i] = (ZERO_REG != 0) && (id_addr_c[i] == '0);
      ex_zero_c[i] = (ZERO_REG != 0) && (ex_addr_c[i] == '0);
    end
  end

  assign wb_en_c = wb_rf_r_we && ((ZERO_REG == 0) || (wb_rf_r_addr != '0));

  // EX -> MEM destination pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rf_r_addr <= '0;
      mem_rf_r_we   <= 1'b0;
      mem_load      <= 1'b0;
    end else if (!ex_stall) begin
      mem_rf_r_addr <= ex_rf_r_addr;
      mem_rf_r_we   <= ex_rf_r_we;
      mem_load      <= ex_rf_r_load;
    end
  end

  // Storage array; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wb_en_c) begin
      regs[wb_rf_r_addr] <= wb_rf_r;
    end
  end

  // Registered read with write-through of the same-cycle write-back
  always_ff @(posedge clk) begin
    if (!id_stall) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (wb_en_c && (wb_rf_r_addr == id_addr_c[i])) begin
          rd_q[i] <= wb_rf_r;
        end else begin
          rd_q[i] <= regs[id_addr_c[i]];
        end
      end
    end
  end

`ifdef ECO32F_RF_FORWARD_EN
  logic [NUM_RD-1:0] fx_q;
  logic [NUM_RD-1:0] fm_q;

  // Forward flags resolved in ID, consumed in EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fx_q <= '0;
      fm_q <= '0;
    end else if (!id_stall) begin
      for (int i = 0; i < NUM_RD; i++) begin
        fx_q[i] <= ex_rf_r_we && (ex_rf_r_addr == id_addr_c[i]) && !id_zero_c[i];
        fm_q[i] <= mem_rf_r_we && (mem_rf_r_addr == id_addr_c[i]) && !id_zero_c[i];
      end
    end
  end

  assign unused_c = mem_load;
`else
  assign unused_c = ^{mem_load, mem_alu_result};
`endif

  // Operand select: zero reg, then youngest producer, then array
  always_comb begin
    ex_rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ex_zero_c[i]) begin
        ex_rd_data[i*DW +: DW] = '0;
`ifdef ECO32F_RF_FORWARD_EN
      end else if (fx_q[i]) begin
        ex_rd_data[i*DW +: DW] = mem_alu_result;
      end else if (fm_q[i]) begin
        ex_rd_data[i*DW +: DW] = wb_rf_r;
`endif
      end else begin
        ex_rd_data[i*DW +: DW] = rd_q[i];
      end
    end
  end

  // Stall request: load-use with forwarding, any EX/MEM RAW without
  always_comb begin
    id_hazard = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (id_rd_valid[i] && !id_zero_c[i]) begin
`ifdef ECO32F_RF_FORWARD_EN
        if (ex_rf_r_we && ex_rf_r_load && (ex_rf_r_addr == id_addr_c[i])) begin
          id_hazard = 1'b1;
        end
`else
        if ((ex_rf_r_we && (ex_rf_r_addr == id_addr_c[i])) ||
            (mem_rf_r_we && (mem_rf_r_addr == id_addr_c[i]))) begin
          id_hazard = 1'b1;
        end
`endif
      end
    end
    if (rst) begin
      id_hazard = 1'b0;
    end
  end

endmodule

// File: tb/tb_eco32f_registerfile_mp.sv
// Directed scoreboard bench for eco32f_registerfile_mp; expectations follow ECO32F_RF_FORWARD_EN.
module tb_eco32f_registerfile_mp;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
`ifdef ECO32F_RF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_stall, ex_stall;
  logic [NR-1:0]    id_rd_valid;
  logic [NR*AW-1:0] id_rd_addr, ex_rd_addr;
  logic [AW-1:0]    ex_rf_r_addr, mem_rf_r_addr, wb_rf_r_addr;
  logic             ex_rf_r_we, ex_rf_r_load, mem_rf_r_we, wb_rf_r_we;
  logic [DW-1:0]    mem_alu_result, wb_rf_r;
  logic [NR*DW-1:0] ex_rd_data;
  logic             id_hazard;

  eco32f_registerfile_mp dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .ex_stall(ex_stall),
    .id_rd_valid(id_rd_valid), .id_rd_addr(id_rd_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rf_r_addr(ex_rf_r_addr), .ex_rf_r_we(ex_rf_r_we), .ex_rf_r_load(ex_rf_r_load),
    .mem_rf_r_addr(mem_rf_r_addr), .mem_rf_r_we(mem_rf_r_we),
    .mem_alu_result(mem_alu_result), .ex_rd_data(ex_rd_data), .id_hazard(id_hazard),
    .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r(wb_rf_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic [31:0] exp, input string tag);
    exp_t e;
    e.port = port;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, ex_rd_data[e.port*DW +: DW], e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Capture edge: the ID addresses move into EX
  task automatic cap();
    logic [NR*AW-1:0] a;
    a = id_rd_addr;
    tick();
    ex_rd_addr = a;
  endtask

  task automatic set_id(input logic [NR-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    id_rd_valid = v;
    id_rd_addr  = {a1, a0};
  endtask

  task automatic set_ex(input logic we, input logic ld, input logic [AW-1:0] a);
    ex_rf_r_we   = we;
    ex_rf_r_load = ld;
    ex_rf_r_addr = a;
  endtask

  task automatic set_wb(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    wb_rf_r_we   = we;
    wb_rf_r_addr = a;
    wb_rf_r      = d;
  endtask

  initial begin
    // Reset with a load-use pattern on the inputs
    rst = 1'b1;
    id_stall = 1'b0;
    ex_stall = 1'b0;
    ex_rd_addr = '0;
    mem_alu_result = '0;
    set_id(2'b11, 5'd9, 5'd9);
    set_ex(1'b1, 1'b1, 5'd9);
    set_wb(1'b0, 5'd0, 32'h0);
    #8;
    chk("rst_mem_addr", 32'(mem_rf_r_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_rf_r_we), 32'd0);
    chk("rst_hazard", 32'(id_hazard), 32'd0);
    set_id(2'b00, 5'd0, 5'd0);
    set_ex(1'b0, 1'b0, 5'd0);
    #4;
    rst = 1'b0;
    tick();

    // Write r5, then read it back
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(2'b11, 5'd5, 5'd0);
    push(0, 32'hDEADBEEF, "rd_r5");
    push(1, 32'h0, "rd_r0_p1");
    cap();
    check_rd();

    // Write-through of r7
    set_wb(1'b1, 5'd7, 32'h12345678);
    set_id(2'b11, 5'd7, 5'd5);
    push(0, 32'h12345678, "wthru_r7");
    push(1, 32'hDEADBEEF, "rd_r5_p1");
    cap();
    set_wb(1'b0, 5'd0, 32'h0);
    check_rd();

    // r0 ignores writes and never hazards
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    set_id(2'b11, 5'd0, 5'd0);
    push(0, 32'h0, "zero_p0");
    push(1, 32'h0, "zero_p1");
    cap();
    set_wb(1'b0, 5'd0, 32'h0);
    check_rd();
    set_ex(1'b1, 1'b1, 5'd0);
    #1;
    chk("zero_hazard", 32'(id_hazard), 32'd0);
    set_ex(1'b0, 1'b0, 5'd0);
    set_wb(1'b1, 5'd3, 32'h33333333);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);

    // EX forward of r3 on port 1
    set_ex(1'b1, 1'b0, 5'd3);
    set_id(2'b10, 5'd5, 5'd3);
    #1;
    chk("exfwd_hazard", 32'(id_hazard), FWD ? 32'd0 : 32'd1);
    push(1, FWD ? 32'h00000042 : 32'h33333333, "exfwd_r3");
    cap();
    chk("mem_addr_r3", 32'(mem_rf_r_addr), 32'd3);
    chk("mem_we_r3", 32'(mem_rf_r_we), 32'd1);
    mem_alu_result = 32'h00000042;
    check_rd();

    // EX and MEM both target r3: youngest producer wins
    #1;
    chk("exmem_hazard", 32'(id_hazard), FWD ? 32'd0 : 32'd1);
    push(0, 32'hDEADBEEF, "exmem_p0");
    push(1, FWD ? 32'h77777777 : 32'h33333333, "exmem_fx_wins");
    cap();
    set_ex(1'b0, 1'b0, 5'd0);
    mem_alu_result = 32'h77777777;
    wb_rf_r = 32'h55555555;
    check_rd();
    set_id(2'b00, 5'd0, 5'd0);
    tick();

    // Load-use on r9
    set_wb(1'b1, 5'd9, 32'h99999999);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_ex(1'b1, 1'b1, 5'd9);
    set_id(2'b01, 5'd9, 5'd5);
    #1;
    chk("loaduse_hazard", 32'(id_hazard), 32'd1);
    id_stall = 1'b1;
    tick();
    set_ex(1'b0, 1'b0, 5'd0);
`ifdef ECO32F_RF_FORWARD_EN
    id_stall = 1'b0;
    #1;
    chk("loaduse_clear", 32'(id_hazard), 32'd0);
    push(0, 32'hCAFEF00D, "loaduse_fm");
    cap();
    set_wb(1'b1, 5'd9, 32'hCAFEF00D);
    check_rd();
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
`else
    #1;
    chk("loaduse_mem_hazard", 32'(id_hazard), 32'd1);
    tick();
    id_stall = 1'b0;
    set_wb(1'b1, 5'd9, 32'hCAFEF00D);
    #1;
    chk("loaduse_clear", 32'(id_hazard), 32'd0);
    push(0, 32'hCAFEF00D, "loaduse_wthru");
    cap();
    set_wb(1'b0, 5'd0, 32'h0);
    check_rd();
`endif
    set_id(2'b00, 5'd9, 5'd5);

    // ex_stall freezes the MEM registers
    set_ex(1'b1, 1'b0, 5'd12);
    tick();
    ex_stall = 1'b1;
    set_ex(1'b0, 1'b0, 5'd20);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("exstall_addr", 32'(mem_rf_r_addr), 32'd12);
      chk("exstall_we", 32'(mem_rf_r_we), 32'd1);
    end
    ex_stall = 1'b0;
    tick();
    chk("exstall_rel_addr", 32'(mem_rf_r_addr), 32'd20);
    chk("exstall_rel_we", 32'(mem_rf_r_we), 32'd0);

    // id_stall holds operands across a write to the read address
    set_id(2'b00, 5'd5, 5'd9);
    push(0, 32'hDEADBEEF, "pre_stall_r5");
    push(1, 32'hCAFEF00D, "pre_stall_r9");
    cap();
    check_rd();
    id_stall = 1'b1;
    set_wb(1'b1, 5'd5, 32'h0BADF00D);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    push(0, 32'hDEADBEEF, "idstall_hold_r5");
    push(1, 32'hCAFEF00D, "idstall_hold_r9");
    check_rd();
    id_stall = 1'b0;
    push(0, 32'h0BADF00D, "post_stall_r5");
    cap();
    check_rd();

    // Async reset with fx set
    set_ex(1'b1, 1'b0, 5'd5);
    set_id(2'b00, 5'd5, 5'd9);
    cap();
    set_ex(1'b0, 1'b0, 5'd0);
    mem_alu_result = 32'h11111111;
    chk("pre_rst_mem_we", 32'(mem_rf_r_we), 32'd1);
    push(0, FWD ? 32'h11111111 : 32'h0BADF00D, "pre_rst_fx");
    check_rd();
    rst = 1'b1;
    #1;
    chk("async_rst_mem_we", 32'(mem_rf_r_we), 32'd0);
    chk("async_rst_mem_addr", 32'(mem_rf_r_addr), 32'd0);
    chk("async_rst_flags", ex_rd_data[0 +: DW], 32'h0BADF00D);
    rst = 1'b0;
    set_id(2'b00, 5'd9, 5'd7);
    push(0, 32'hCAFEF00D, "post_rst_r9");
    push(1, 32'h12345678, "post_rst_r7");
    cap();
    check_rd();

    // Non-load RAW on r4 and invalid ports
    set_ex(1'b1, 1'b0, 5'd4);
    set_id(2'b01, 5'd4, 5'd0);
    #1;
    chk("r4_nonload", 32'(id_hazard), FWD ? 32'd0 : 32'd1);
    set_id(2'b00, 5'd4, 5'd4);
    #1;
    chk("r4_invalid", 32'(id_hazard), 32'd0);
    set_ex(1'b1, 1'b1, 5'd4);
    #1;
    chk("r4_load_invalid", 32'(id_hazard), 32'd0);
    set_id(2'b10, 5'd0, 5'd4);
    #1;
    chk("r4_load_p1", 32'(id_hazard), 32'd1);
    set_ex(1'b0, 1'b0, 5'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
